// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: tracks destinations of in-flight long-latency
// ops and stalls decode on RAW/WAW hazards that writeback forwarding cannot cover.
module reg_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue_valid,
  input  logic             i_flush,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [4:0]       i_rd,
  input  logic             i_issue_long,
  input  logic             i_wb_reg_write,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_long,
  output logic             o_stall,
  output logic [31:0]      o_pending,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_err
);

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_PIM    = 7'b0001011;

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] busy;
  logic        rs1_used, rs2_used, rd_written;
  logic        raw, waw, full;
  logic        stall, issue, inc;

  // A retiring long op's register is covered by forwarding this cycle.
  always_comb begin
    clr_mask = '0;
    if (i_wb_long && i_wb_reg_write && (i_wb_rd != 5'd0)) clr_mask[i_wb_rd] = 1'b1;
  end

  assign busy = pending_q & ~clr_mask;

  assign rs1_used   = !((i_opcode == OPCODE_JAL) || (i_opcode == OPCODE_LUI) ||
                        (i_opcode == OPCODE_AUIPC));
  assign rs2_used   = (i_opcode == OPCODE_OP) || (i_opcode == OPCODE_STORE) ||
                      (i_opcode == OPCODE_BRANCH) || (i_opcode == OPCODE_PIM);
  assign rd_written = !((i_opcode == OPCODE_STORE) || (i_opcode == OPCODE_BRANCH));

  assign raw  = (rs1_used && busy[i_rs1]) || (rs2_used && busy[i_rs2]);
  // Short ops also wait on a pending rd so the later long writeback cannot clobber them.
  assign waw  = (i_issue_long || rd_written) && busy[i_rd];
  assign full = i_issue_long && (cnt_q == CNT_W'(MAX_OUTSTANDING)) && !i_wb_long;

  assign stall = i_issue_valid && !i_flush && (raw || waw || full);
  assign issue = i_issue_valid && !i_flush && !stall;
  assign inc   = issue && i_issue_long;

  always_comb begin
    set_mask = '0;
    if (inc && (i_rd != 5'd0)) set_mask[i_rd] = 1'b1;
  end

  assign pending_d = (pending_q & ~clr_mask) | set_mask;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !i_wb_long) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc && i_wb_long) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_stall       = stall;
  assign o_pending     = pending_q;
  assign o_outstanding = cnt_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, async-reset sequence, and
// randomized traffic checked against a register-set model.
module tb_reg_scoreboard;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] PIM    = 7'b0001011;
  localparam int MAXO = 4;

  logic        i_clk, i_rst_n;
  logic        i_issue_valid, i_flush, i_issue_long;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rs1, i_rs2, i_rd, i_wb_rd;
  logic        i_wb_reg_write, i_wb_long;
  logic        o_stall, o_err;
  logic [31:0] o_pending;
  logic [3:0]  o_outstanding;

  reg_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_issue_valid(i_issue_valid), .i_flush(i_flush),
    .i_opcode(i_opcode), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_issue_long(i_issue_long), .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd),
    .i_wb_long(i_wb_long), .o_stall(o_stall), .o_pending(o_pending),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  // clock/reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v, fl; logic [6:0] op; logic [4:0] rs1, rs2, rd; logic lg;
    logic wrw; logic [4:0] wrd; logic wl;
    logic stall; logic [31:0] pend; logic [3:0] out; logic err;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic v, input logic fl, input logic [6:0] op,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic lg, input logic wrw, input logic [4:0] wrd,
                              input logic wl, input logic stall, input logic [31:0] pend,
                              input logic [3:0] out, input logic err);
    vec_t t;
    t.v = v; t.fl = fl; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.lg = lg;
    t.wrw = wrw; t.wrd = wrd; t.wl = wl;
    t.stall = stall; t.pend = pend; t.out = out; t.err = err;
    vecs.push_back(t);
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic fl, input logic [6:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic lg, input logic wrw, input logic [4:0] wrd, input logic wl);
    i_issue_valid = v; i_flush = fl; i_opcode = op; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_issue_long = lg; i_wb_reg_write = wrw; i_wb_rd = wrd; i_wb_long = wl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, OPIMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // reference model: set of pending registers, plain integer count, sticky error
  bit m_pend[32];
  int m_cnt;
  bit m_err;

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[i] = m_pend[i];
    return r;
  endfunction

  function automatic bit m_busy(input int r);
    bit retiring = i_wb_long && i_wb_reg_write && (int'(i_wb_rd) == r);
    return (r != 0) && m_pend[r] && !retiring;
  endfunction

  function automatic bit m_stall();
    bit use1 = !(i_opcode inside {JAL, LUI, AUIPC});
    bit use2 = i_opcode inside {OP, STORE, BRANCH, PIM};
    bit wrd  = !(i_opcode inside {STORE, BRANCH});
    bit haz  = (use1 && m_busy(i_rs1)) || (use2 && m_busy(i_rs2)) ||
               ((i_issue_long || wrd) && m_busy(i_rd)) ||
               (i_issue_long && m_cnt == MAXO && !i_wb_long);
    return i_issue_valid && !i_flush && haz;
  endfunction

  function automatic void m_step(input bit stall);
    bit iss = i_issue_valid && !i_flush && !stall;
    if (i_wb_long && i_wb_reg_write) m_pend[i_wb_rd] = 1'b0;
    if (iss && i_issue_long && i_rd != 0) m_pend[i_rd] = 1'b1;
    m_cnt = m_cnt + ((iss && i_issue_long) ? 1 : 0) - (i_wb_long ? 1 : 0);
    if (m_cnt < 0) begin
      m_cnt = 0;
      m_err = 1'b1;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    idle();
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    m_reset();
  endtask

  initial begin
    vec_t t;
    logic [6:0] ops[9];
    bit exp_stall;
    ops = '{LOAD, OP, OPIMM, LUI, STORE, BRANCH, PIM, JAL, AUIPC};

    //   v  fl op     rs1 rs2 rd lg wrw wrd wl  stall pend        out err
    add(0, 0, OPIMM,  0,  0,  0, 0, 0,  0, 0,  0, 32'h0,      0, 0);
    add(1, 0, LOAD,   1,  0,  5, 1, 0,  0, 0,  0, 32'h20,     1, 0);
    add(1, 0, OP,     5,  6,  8, 0, 0,  0, 0,  1, 32'h20,     1, 0);
    add(1, 0, OP,     5,  6,  8, 0, 0,  0, 0,  1, 32'h20,     1, 0);
    add(1, 0, OP,     5,  6,  8, 0, 1,  5, 1,  0, 32'h0,      0, 0);
    add(1, 0, LOAD,   0,  0,  5, 1, 0,  0, 0,  0, 32'h20,     1, 0);
    add(1, 0, LOAD,   0,  0,  5, 1, 0,  0, 0,  1, 32'h20,     1, 0);
    add(1, 0, OP,     1,  2,  5, 0, 0,  0, 0,  1, 32'h20,     1, 0);
    add(1, 0, LUI,    5,  0,  7, 0, 0,  0, 0,  0, 32'h20,     1, 0);
    add(1, 0, OPIMM,  1,  5,  8, 0, 0,  0, 0,  0, 32'h20,     1, 0);
    add(1, 0, STORE,  1,  5,  3, 0, 0,  0, 0,  1, 32'h20,     1, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 1,  5, 1,  0, 32'h0,      0, 0);
    add(1, 0, LOAD,   0,  0,  1, 1, 0,  0, 0,  0, 32'h2,      1, 0);
    add(1, 0, LOAD,   0,  0,  2, 1, 0,  0, 0,  0, 32'h6,      2, 0);
    add(1, 0, LOAD,   0,  0,  3, 1, 0,  0, 0,  0, 32'hE,      3, 0);
    add(1, 0, LOAD,   0,  0,  4, 1, 0,  0, 0,  0, 32'h1E,     4, 0);
    add(1, 0, LOAD,   0,  0,  6, 1, 0,  0, 0,  1, 32'h1E,     4, 0);
    add(1, 0, LOAD,   0,  0,  6, 1, 1,  1, 1,  0, 32'h5C,     4, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 1,  2, 1,  0, 32'h58,     3, 0);
    add(1, 0, LOAD,   0,  0,  9, 1, 0,  0, 0,  0, 32'h258,    4, 0);
    add(1, 0, LOAD,   0,  0,  9, 1, 1,  9, 1,  0, 32'h258,    4, 0);
    add(1, 1, LOAD,   0,  0,  3, 1, 0,  0, 0,  0, 32'h258,    4, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 1,  3, 1,  0, 32'h250,    3, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 1,  4, 1,  0, 32'h240,    2, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 1,  6, 1,  0, 32'h200,    1, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 1,  9, 1,  0, 32'h0,      0, 0);
    add(0, 0, OPIMM,  0,  0,  0, 0, 0,  0, 1,  0, 32'h0,      0, 1);
    add(0, 0, OPIMM,  0,  0,  0, 0, 0,  0, 0,  0, 32'h0,      0, 1);

    do_reset();
    check("reset_pending", o_pending, 32'h0);
    check("reset_outstanding", 32'(o_outstanding), 32'h0);
    check("reset_err", 32'(o_err), 32'h0);
    check("reset_stall", 32'(o_stall), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t.v, t.fl, t.op, t.rs1, t.rs2, t.rd, t.lg, t.wrw, t.wrd, t.wl);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(o_stall), 32'(t.stall));
      @(posedge i_clk);
      #1;
      check($sformatf("vec%0d_pending", i), o_pending, t.pend);
      check($sformatf("vec%0d_outstanding", i), 32'(o_outstanding), 32'(t.out));
      check($sformatf("vec%0d_err", i), 32'(o_err), 32'(t.err));
    end

    // Reset asserted mid-cycle with a load in flight and err set clears everything at once.
    drive(1, 0, LOAD, 0, 0, 5, 1, 0, 0, 0);
    @(posedge i_clk);
    #1;
    idle();
    check("pre_reset_pending", o_pending, 32'h20);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_reset_pending", o_pending, 32'h0);
    check("async_reset_outstanding", 32'(o_outstanding), 32'h0);
    check("async_reset_err", 32'(o_err), 32'h0);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    m_reset();

    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      logic lg, wl;
      op = ops[$urandom_range(0, 8)];
      lg = (op == LOAD) || (op == PIM && $urandom_range(0, 1) == 1);
      wl = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, op,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            lg, $urandom_range(0, 6) != 0, 5'($urandom_range(0, 7)), wl);
      #1;
      exp_stall = m_stall();
      check($sformatf("rnd%0d_stall", n), 32'(o_stall), 32'(exp_stall));
      m_step(exp_stall);
      exp_q.push_back(m_pend_vec());
      @(posedge i_clk);
      #1;
      check($sformatf("rnd%0d_pending", n), o_pending, exp_q.pop_front());
      check($sformatf("rnd%0d_outstanding", n), 32'(o_outstanding), 32'(m_cnt));
      check($sformatf("rnd%0d_err", n), 32'(o_err), 32'(m_err));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
